lane_frame_accumulator: RTL

- Parametrised successor to the team's packed-lane accumulator. Sums Wc independent unsigned lanes of W bits over frames of N_ACC accepted samples.
- Emits one packed frame sum per frame into the output FIFO.
- Adds valid/ready handshakes on both sides, selectable wrap or saturate arithmetic, per-lane overflow flags and a synchronous frame clear.
- Sits between the input FIFO read port and the output FIFO write port in the UART datapath.

---
 rtl/uart_acc_pkg.sv | 16 +
 rtl/acc_lane.sv | 26 ++
 rtl/lane_frame_accumulator.sv | 93 +++++++++
 3 files changed

// File: rtl/uart_acc_pkg.sv
// Shared defaults and arithmetic-mode constants for the lane frame accumulator.
package uart_acc_pkg;

  localparam int ACC_W_DEF  = 6;
  localparam int ACC_WC_DEF = 4;
  localparam int ACC_N_DEF  = 8;

  localparam int ACC_WRAP = 0;
  localparam int ACC_SAT  = 1;

  // Sample counter width; a one-sample frame still needs a 1-bit counter.
  function automatic int acc_cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/acc_lane.sv
// One W-bit lane adder with wrap or saturate behaviour and a carry flag.
module acc_lane
  import uart_acc_pkg::*;
#(
  parameter int W   = ACC_W_DEF,
  parameter int SAT = ACC_WRAP
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r,
  output logic         c
);

  logic [W:0] s;

  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    c = s[W];
    if ((SAT == ACC_SAT) && s[W]) begin
      r = '1;
    end else begin
      r = s[W-1:0];
    end
  end

endmodule

// File: rtl/lane_frame_accumulator.sv
// Sums Wc packed unsigned lanes over frames of N_ACC accepted samples and
// presents each frame sum through a one-entry output buffer.
module lane_frame_accumulator
  import uart_acc_pkg::*;
#(
  parameter int W     = ACC_W_DEF,
  parameter int Wc    = ACC_WC_DEF,
  parameter int N_ACC = ACC_N_DEF,
  parameter int SAT   = ACC_WRAP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [Wc*W-1:0] x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Wc*W-1:0] y,
  output logic [Wc-1:0]   ovf
);

  localparam int CW = acc_cnt_width(N_ACC);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_ACC - 1);

  logic [Wc*W-1:0] acc;
  logic [Wc*W-1:0] sum;
  logic [Wc-1:0]   ovf_acc;
  logic [Wc-1:0]   carry;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            accept;
  logic            done;

  for (genvar i = 0; i < Wc; i++) begin : g_lane
    acc_lane #(
      .W   (W),
      .SAT (SAT)
    ) u_lane (
      .a (acc[i*W +: W]),
      .b (x[i*W +: W]),
      .r (sum[i*W +: W]),
      .c (carry[i])
    );
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Input stalls only when the closing sample would overwrite an undelivered
  // result; in_ready depends on clr/out_ready/state, never on in_valid.
  assign last     = (cnt == LAST_CNT);
  assign in_ready = !clr && !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign done     = accept && last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= '0;
    end else if (clr) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= '0;
    end else if (accept) begin
      if (last) begin
        acc     <= '0;
        cnt     <= '0;
        ovf_acc <= '0;
      end else begin
        acc     <= sum;
        cnt     <= cnt + 1'b1;
        ovf_acc <= ovf_acc | carry;
      end
    end
  end

  // A completing frame takes priority, so a same-cycle drain and refill
  // keeps out_valid high with no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y         <= '0;
      ovf       <= '0;
      out_valid <= 1'b0;
    end else if (done) begin
      y         <= sum;
      ovf       <= ovf_acc | carry;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
